instr_mem_loader: RTL and testbench

Program loader that fills the CPU instruction memory before execution. It accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Each word is written through the CPU's `initialize` / `instruction_initialize_data` / `instruction_initialize_address` port. It holds the CPU in reset while loading and releases it once the last word is written. It sits between the test/host side and the `cpu` top level, and is the write end of the instruction-memory initialization interface.

---
 rtl/instr_mem_loader.sv | 141 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words and writes them
// into the CPU instruction memory while holding the CPU in reset.
`timescale 1ns/1ps

module instr_mem_loader #(
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned RST_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned HOLD_W    = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned HOLD_LAST = (RST_HOLD > 1) ? RST_HOLD - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        RELEASE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [23:0]        word_buf;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               start_legal;
    logic               xfer;
    logic [31:0]        asm_word;
    logic [CNT_W-1:0]   word_idx_nxt;

    // Newest byte always enters at the bottom, so the first byte ends up in [31:24].
    assign asm_word     = {word_buf, byte_data};
    assign xfer         = byte_valid && byte_ready;
    assign start_legal  = (word_count != 8'd0) && (32'(word_count) <= MAX_WORDS);
    assign word_idx_nxt = CNT_W'(word_idx + CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                          <= IDLE;
            byte_ready                     <= 1'b0;
            initialize                     <= 1'b0;
            instruction_initialize_data    <= 32'd0;
            instruction_initialize_address <= 32'd0;
            cpu_rst                        <= 1'b1;
            busy                           <= 1'b0;
            done                           <= 1'b0;
            error                          <= 1'b0;
            word_cnt                       <= '0;
            word_idx                       <= '0;
            byte_idx                       <= '0;
            word_buf                       <= '0;
            hold_cnt                       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            word_cnt   <= word_count;
                            error      <= 1'b0;
                            cpu_rst    <= 1'b1;
                            word_idx   <= '0;
                            byte_idx   <= '0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            state      <= COLLECT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (xfer) begin
                        word_buf <= asm_word[23:0];
                        byte_idx <= 2'(byte_idx + 2'd1);
                        if (byte_idx == 2'd3) begin
                            byte_ready                     <= 1'b0;
                            initialize                     <= 1'b1;
                            instruction_initialize_data    <= asm_word;
                            instruction_initialize_address <= 32'({word_idx, 2'b00});
                            state                          <= WRITE;
                        end
                    end
                end

                // Single-cycle write strobe; memory captures at the edge leaving this state.
                WRITE: begin
                    initialize <= 1'b0;
                    word_idx   <= word_idx_nxt;
                    if (word_idx_nxt == word_cnt) begin
                        hold_cnt <= '0;
                        state    <= RELEASE;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= COLLECT;
                    end
                end

                RELEASE: begin
                    if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= HOLD_W'(hold_cnt + HOLD_W'(1));
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Structural invariants of the handshake and write strobe.
    a_init_one_cycle: assert property (@(posedge clk) disable iff (rst)
        initialize |=> !initialize);
    a_no_ready_in_write: assert property (@(posedge clk) disable iff (rst)
        !(initialize && byte_ready));
    a_done_clean: assert property (@(posedge clk) disable iff (rst)
        done |-> (!busy && !cpu_rst));

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: session-level reference model plus
// write scoreboard, compared against the DUT on every falling clock edge.
`timescale 1ns/1ps

module tb_instr_mem_loader;

    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned RST_HOLD  = 2;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  word_count = 8'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        initialize;
    logic [31:0] instruction_initialize_data;
    logic [31:0] instruction_initialize_address;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    always #5 if (clk_en) clk = ~clk;

    instr_mem_loader #(.MAX_WORDS(MAX_WORDS), .RST_HOLD(RST_HOLD)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .word_count                     (word_count),
        .byte_valid                     (byte_valid),
        .byte_data                      (byte_data),
        .byte_ready                     (byte_ready),
        .initialize                     (initialize),
        .instruction_initialize_data    (instruction_initialize_data),
        .instruction_initialize_address (instruction_initialize_address),
        .cpu_rst                        (cpu_rst),
        .busy                           (busy),
        .done                           (done),
        .error                          (error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is a count of bytes taken and words written,
    // followed by a countdown of reset-hold cycles.
    bit          m_active = 0;
    int          m_cnt = 0;
    int          m_taken = 0;
    int          m_written = 0;
    bit          m_wr = 0;
    int          m_hold = 0;
    logic [31:0] m_word = 0;
    logic [31:0] m_data = 0;
    logic [31:0] m_addr = 0;
    bit          m_init = 0;
    bit          m_cpu_rst = 1;
    bit          m_err = 0;
    bit          m_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_cnt = 0; m_taken = 0; m_written = 0; m_wr = 0; m_hold = 0;
            m_word = 0; m_data = 0; m_addr = 0; m_init = 0; m_cpu_rst = 1; m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            m_init = 0;
            if (!m_active) begin
                if (start) begin
                    if (word_count >= 1 && int'(word_count) <= int'(MAX_WORDS)) begin
                        m_active = 1; m_cnt = int'(word_count); m_taken = 0; m_written = 0;
                        m_wr = 0; m_hold = 0; m_err = 0; m_cpu_rst = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (m_wr) begin
                m_wr = 0;
                m_written++;
                if (m_written == m_cnt) m_hold = int'(RST_HOLD);
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_active = 0; m_cpu_rst = 0; m_done = 1;
                end
            end else if (byte_valid) begin
                m_word = {m_word[23:0], byte_data};
                m_taken++;
                if (m_taken % 4 == 0) begin
                    m_wr = 1; m_init = 1; m_data = m_word; m_addr = 32'(m_written * 4);
                end
            end
        end
    end

    // Write scoreboard and simple instruction memory image.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] imem [0:MAX_WORDS-1];
    logic [31:0] last_addr = 0;
    int          n_done = 0;
    int          n_writes = 0;
    bit          prev_init = 0;

    always @(negedge clk) begin
        chk("byte_ready", 32'(byte_ready), 32'(m_active && !m_wr && m_hold == 0));
        chk("initialize", 32'(initialize), 32'(m_init));
        chk("data", instruction_initialize_data, m_data);
        chk("addr", instruction_initialize_address, m_addr);
        chk("cpu_rst", 32'(cpu_rst), 32'(m_cpu_rst));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("init_single", 32'(prev_init && initialize), 32'd0);
        prev_init = initialize;
        if (initialize) begin
            n_writes++;
            last_addr = instruction_initialize_address;
            imem[instruction_initialize_address[5:2]] = instruction_initialize_data;
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                chk("sb_addr", instruction_initialize_address, exp_addr_q.pop_front());
                chk("sb_data", instruction_initialize_data, exp_data_q.pop_front());
            end
        end
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] wc);
        start = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
        word_count = 8'($urandom);
    endtask

    // gap_mode 0: back-to-back, 1: one idle cycle per byte, 2: random idle cycles.
    task automatic send_bytes(input logic [7:0] b[$], input int gap_mode, input int mid_start);
        for (int i = 0; i < b.size(); i++) begin
            int guard = 0;
            byte_valid = 1'b1;
            byte_data  = b[i];
            if (i == mid_start) begin
                start = 1'b1;
                word_count = 8'd3;
            end
            while (!byte_ready && guard < 100) begin
                tick();
                start = 1'b0;
                guard++;
            end
            if (guard >= 100) begin
                chk("ready_timeout", 32'd0, 32'd1);
                byte_valid = 1'b0;
                return;
            end
            tick();
            start = 1'b0;
            byte_valid = 1'b0;
            byte_data = 8'($urandom);
            if (gap_mode == 1) tick();
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic wait_done(input int d0);
        int guard = 0;
        while (n_done == d0 && guard < 50) begin
            tick();
            guard++;
        end
        if (n_done == d0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_words(input logic [7:0] b[$], input int nw);
        for (int w = 0; w < nw; w++) begin
            exp_addr_q.push_back(32'(w * 4));
            exp_data_q.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
        end
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] b[$]);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] rb[$];
        int d0, w0;

        repeat (2) tick();
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_init", 32'(initialize), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        tick();

        // Directed two-word load, back-to-back bytes.
        prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
        exp_addr_q.push_back(32'h0);  exp_data_q.push_back(32'h20010005);
        exp_addr_q.push_back(32'h4);  exp_data_q.push_back(32'h8C020004);
        d0 = n_done; w0 = n_writes;
        do_start(8'd2);
        send_bytes(prog, 0, -1);
        wait_done(d0);
        repeat (3) tick();
        chk("s1_writes", 32'(n_writes - w0), 32'd2);
        chk("s1_done_once", 32'(n_done - d0), 32'd1);
        chk("s1_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("s1_fetch_pc0", imem[0], 32'h20010005);
        chk("s1_pending", 32'(exp_addr_q.size()), 32'd0);

        // Same load with byte_valid toggling.
        push_words(prog, 2);
        d0 = n_done; w0 = n_writes;
        do_start(8'd2);
        send_bytes(prog, 1, -1);
        wait_done(d0);
        tick();
        chk("s2_writes", 32'(n_writes - w0), 32'd2);
        chk("s2_pending", 32'(exp_addr_q.size()), 32'd0);

        // Rejected starts, then a valid start clears error.
        do_start(8'd0);
        tick();
        chk("err0_error", 32'(error), 32'd1);
        chk("err0_busy", 32'(busy), 32'd0);
        do_start(8'd17);
        tick();
        chk("err17_error", 32'(error), 32'd1);
        chk("err17_cpu_rst", 32'(cpu_rst), 32'd0);

        // Async reset with clock stopped.
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_error", 32'(error), 32'd0);
        chk("async_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("async_data", instruction_initialize_data, 32'd0);
        #2 rst = 1'b0;
        clk_en = 1'b1;
        tick();

        rand_bytes(4, rb);
        push_words(rb, 1);
        d0 = n_done;
        do_start(8'd1);
        chk("accept_error_clr", 32'(error), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        send_bytes(rb, 0, -1);
        wait_done(d0);
        tick();

        // Full-depth load with a stray start mid-session.
        rand_bytes(4 * MAX_WORDS, rb);
        push_words(rb, MAX_WORDS);
        d0 = n_done;
        do_start(8'(MAX_WORDS));
        send_bytes(rb, 2, 21);
        wait_done(d0);
        tick();
        chk("full_last_addr", last_addr, 32'h3C);
        chk("full_pending", 32'(exp_addr_q.size()), 32'd0);

        // Reset after two bytes of the second word.
        rand_bytes(6, rb);
        push_words(rb, 1);
        do_start(8'd2);
        send_bytes(rb, 0, -1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_addr", instruction_initialize_address, 32'd0);
        chk("mid_rst_data", instruction_initialize_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pending", 32'(exp_addr_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rand_bytes(4, rb);
        push_words(rb, 1);
        d0 = n_done;
        do_start(8'd1);
        send_bytes(rb, 0, -1);
        wait_done(d0);
        tick();
        chk("mid_rst_new_addr", last_addr, 32'h0);

        // Randomized sessions with occasional illegal starts.
        for (int s = 0; s < 8; s++) begin
            int wc;
            if ($urandom_range(0, 3) == 0) begin
                do_start(8'($urandom_range(MAX_WORDS + 1, 255)));
                tick();
            end
            wc = int'($urandom_range(1, MAX_WORDS));
            rand_bytes(4 * wc, rb);
            push_words(rb, wc);
            d0 = n_done;
            do_start(8'(wc));
            send_bytes(rb, int'($urandom_range(0, 2)), -1);
            wait_done(d0);
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();
        chk("final_pending", 32'(exp_addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
